// File: rtl/mem_burst_master.sv
// Burst initiator for the data-memory port: streams words into memory or reads a
// contiguous, wrapping address range back out as a handshaked stream.
module mem_burst_master #(
   parameter int unsigned N  = 17,
   parameter int unsigned AW = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_write,
   input  logic [AW-1:0] i_cmd_base,
   input  logic [AW-1:0] i_cmd_len,
   input  logic          i_wr_valid,
   output logic          o_wr_ready,
   input  logic [N-1:0]  i_wr_data,
   output logic          o_rd_valid,
   input  logic          i_rd_ready,
   output logic [11:0]   o_rd_data,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_mem_write_en,
   output logic [AW-1:0] o_mem_addr,
   output logic [N-1:0]  o_mem_datain,
   input  logic [11:0]   i_mem_dataout
);

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StRdIssue,
      StRdWait,
      StRdCap,
      StRdOut,
      StDone
   } state_e;

   state_e        r_state;
   logic [AW-1:0] r_base;
   logic [AW-1:0] r_len;
   logic [AW-1:0] r_idx;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [N-1:0]  r_mem_datain;
   logic          r_rd_valid;
   logic [11:0]   r_rd_data;
   logic          r_done;

   logic [AW-1:0] w_addr;
   logic          w_last;

   // AW-bit addition wraps modulo 2**AW by construction
   assign w_addr = r_base + r_idx;
   assign w_last = (r_idx == r_len - AW'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_base       <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_datain <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_done       <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_cmd_valid) begin
                  r_base <= i_cmd_base;
                  r_len  <= i_cmd_len;
                  r_idx  <= '0;
                  if (i_cmd_len == '0) begin
                     r_state <= StDone;
                  end else if (i_cmd_write) begin
                     r_state <= StWr;
                  end else begin
                     r_state <= StRdIssue;
                  end
               end
            end
            StWr: begin
               if (i_wr_valid) begin
                  r_mem_we     <= 1'b1;
                  r_mem_addr   <= w_addr;
                  r_mem_datain <= i_wr_data;
                  r_idx        <= r_idx + AW'(1);
                  if (w_last) begin
                     r_state <= StDone;
                  end
               end
            end
            StRdIssue: begin
               r_mem_addr <= w_addr;
               r_state    <= StRdWait;
            end
            StRdWait: begin
               r_state <= StRdCap;
            end
            StRdCap: begin
               r_rd_data  <= i_mem_dataout;
               r_rd_valid <= 1'b1;
               r_state    <= StRdOut;
            end
            StRdOut: begin
               if (i_rd_ready) begin
                  r_rd_valid <= 1'b0;
                  r_idx      <= r_idx + AW'(1);
                  r_state    <= w_last ? StDone : StRdIssue;
               end
            end
            StDone: begin
               r_done  <= 1'b1;
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_cmd_ready    = (r_state == StIdle);
   assign o_wr_ready     = (r_state == StWr);
   assign o_busy         = (r_state != StIdle);
   assign o_rd_valid     = r_rd_valid;
   assign o_rd_data      = r_rd_data;
   assign o_done         = r_done;
   assign o_mem_write_en = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_datain   = r_mem_datain;

endmodule
